// File: rtl/result_serializer_pkg.sv
// result_serializer_pkg: shared constants, FSM states and frame-length helper for the result framer.
package result_serializer_pkg;
  localparam int N_DEF = 3;
  localparam int W_DEF = 16;
  localparam int BUSY_TO_DEF = 8;
  localparam logic [7:0] HDR_BYTE = 8'hA5;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_HI, WAIT_LO, NEXT, FINISH} state_t;
  function automatic int frame_len(int size, int w);
    return 3 + size * size * w / 8;
  endfunction
endpackage

// File: rtl/result_serializer_tx_byte_hs.sv
// tx_byte_hs: one-byte tx_start/tx_busy handshake with uart_tx, with a timeout on busy rising.
module tx_byte_hs
  import result_serializer_pkg::*;
#(
  parameter int BUSY_TO = BUSY_TO_DEF
) (
  input  logic       bclk,
  input  logic       rst,
  input  logic       i_go,
  input  logic [7:0] i_byte,
  input  logic       i_tx_busy,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_ack,
  output logic       o_timeout
);
  localparam int TW = $clog2(BUSY_TO + 1);
  localparam logic [TW-1:0] TO = TW'(BUSY_TO);
  state_t r_st;
  logic [TW-1:0] r_cnt;
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      r_st <= IDLE;
      r_cnt <= '0;
      o_tx_start <= 1'b0;
      o_tx_data <= '0;
      o_ack <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_ack <= 1'b0;
      o_timeout <= 1'b0;
      case (r_st)
        WAIT_HI: begin
          if (i_tx_busy) r_st <= WAIT_LO;
          else if (r_cnt >= TO) begin
            o_timeout <= 1'b1;
            r_st <= IDLE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        WAIT_LO: begin
          if (!i_tx_busy) begin
            o_ack <= 1'b1;
            r_st <= IDLE;
          end
        end
        default: begin
          // tx_data is captured here and held until the next byte is issued
          if (i_go) begin
            o_tx_data <= i_byte;
            o_tx_start <= 1'b1;
            r_cnt <= '0;
            r_st <= WAIT_HI;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/result_serializer.sv
// result_serializer: frames the latched NxN result bus as HDR, size, elements (MSB first), XOR checksum.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int         N       = N_DEF,
  parameter int         W       = W_DEF,
  parameter logic [7:0] HDR     = HDR_BYTE,
  parameter int         BUSY_TO = BUSY_TO_DEF
) (
  input  logic             bclk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [3:0]       i_size,
  input  logic [N*N*W-1:0] i_result,
  input  logic             i_tx_busy,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);
  localparam int EB = W / 8;
  localparam int NB = N * N * EB;
  localparam int RW = $clog2(N);
  localparam int BW = EB > 1 ? $clog2(EB) : 1;
  localparam int SW = $clog2(NB);
  state_t r_st;
  logic [N*N*W-1:0] r_res;
  logic [3:0] r_size;
  logic [1:0] r_part;
  logic [RW-1:0] r_row, r_col;
  logic [BW-1:0] r_bi;
  logic [7:0] r_csum;
  logic [7:0] w_bytes [NB];
  logic [7:0] w_byte;
  logic [SW-1:0] w_sel;
  logic w_ack, w_to, w_go, w_last_col, w_last_row, w_size_ok;
  for (genvar g = 0; g < NB; g++) begin : g_bytes
    assign w_bytes[g] = r_res[g*8 +: 8];
  end
  // part: 0 header, 1 size, 2 element bytes, 3 checksum
  assign w_sel = SW'((int'(r_row) * N + int'(r_col)) * EB + int'(r_bi));
  assign w_byte = r_part == 2'd0 ? HDR : r_part == 2'd1 ? {4'b0, r_size} :
                  r_part == 2'd2 ? w_bytes[w_sel] : r_csum;
  assign w_last_col = (4'(r_col) + 4'd1) == r_size;
  assign w_last_row = (4'(r_row) + 4'd1) == r_size;
  assign w_size_ok = i_size != 4'd0 && i_size <= 4'(N);
  assign w_go = r_st == ISSUE;
  tx_byte_hs #(.BUSY_TO(BUSY_TO)) u_hs (
    .bclk(bclk),
    .rst(rst),
    .i_go(w_go),
    .i_byte(w_byte),
    .i_tx_busy(i_tx_busy),
    .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data),
    .o_ack(w_ack),
    .o_timeout(w_to)
  );
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      r_st <= IDLE;
      r_res <= '0;
      r_size <= '0;
      r_part <= '0;
      r_row <= '0;
      r_col <= '0;
      r_bi <= '0;
      r_csum <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err <= 1'b0;
      case (r_st)
        IDLE: begin
          if (i_start && w_size_ok) begin
            r_res <= i_result;
            r_size <= i_size;
            o_busy <= 1'b1;
            r_st <= LOAD;
          end else if (i_start) o_err <= 1'b1;
        end
        LOAD: begin
          r_part <= 2'd0;
          r_row <= '0;
          r_col <= '0;
          r_bi <= BW'(EB - 1);
          r_csum <= '0;
          r_st <= ISSUE;
        end
        ISSUE: r_st <= WAIT_HI;
        WAIT_HI: begin
          if (w_to) begin
            o_err <= 1'b1;
            o_busy <= 1'b0;
            r_st <= IDLE;
          end else if (w_ack) r_st <= NEXT;
        end
        NEXT: begin
          r_csum <= (r_part == 2'd1 || r_part == 2'd2) ? r_csum ^ w_byte : r_csum;
          r_st <= r_part == 2'd3 ? FINISH : ISSUE;
          if (r_part == 2'd3) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end
          if (r_part != 2'd2) r_part <= r_part + 1'b1;
          else if (r_bi != '0) r_bi <= r_bi - 1'b1;
          else begin
            r_bi <= BW'(EB - 1);
            if (!w_last_col) r_col <= r_col + 1'b1;
            else begin
              r_col <= '0;
              if (w_last_row) r_part <= 2'd3;
              else r_row <= r_row + 1'b1;
            end
          end
        end
        FINISH: r_st <= IDLE;
        default: r_st <= IDLE;
      endcase
    end
  end
endmodule
